cpri_rx_gen_mc: RTL and testbench



---
 rtl/cpri_rx_pkg.sv | 24 ++
 rtl/cpri_rx_ch_buf.sv | 122 ++++++++++++
 rtl/cpri_rx_gen_mc.sv | 164 ++++++++++++++++
 tb/tb_cpri_rx_gen_mc.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpri_rx_pkg.sv
// Shared chip layout, read FSM state and per-chip info bundle
// for the multi-channel CPRI chip receiver.
package cpri_rx_pkg;

    localparam int DATA_W    = 64;
    localparam int AGC_W     = 16;
    localparam int SHIFT_W   = 64;
    localparam int HDR_START = 3;
    localparam int HDR_WORDS = 4;
    localparam int PLD_START = 7;
    localparam int PLD_END   = 90;

    typedef enum logic {
        IDLE,
        READ
    } rd_state_t;

    typedef struct packed {
        logic [AGC_W-1:0]            agc;
        logic [SHIFT_W-1:0]          shift;
        logic [HDR_WORDS*DATA_W-1:0] hdr;
    } chip_info_t;

endpackage

// File: rtl/cpri_rx_ch_buf.sv
// One CPRI channel: chip capture, NUM_BUF-slot word RAM, header/AGC
// staging, slot bookkeeping and sticky overflow.
module cpri_rx_ch_buf
    import cpri_rx_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_BUF    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wen,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic                  i_wlast,
    input  logic [AGC_W-1:0]      i_agc,
    input  logic [SHIFT_W-1:0]    i_shift,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic                  i_release,
    output logic [DATA_W-1:0]     o_rd_data,
    output chip_info_t            o_info,
    output logic                  o_pending,
    output logic                  o_tready,
    output logic                  o_ovf
);

    localparam int BW    = $clog2(NUM_BUF);
    localparam int CW    = BW + 1;
    localparam int DEPTH = NUM_BUF << ADDR_WIDTH;

    logic [DATA_W-1:0]           r_mem [DEPTH];
    chip_info_t                  r_info [NUM_BUF];
    logic [DATA_W-1:0]           r_rd_data;
    logic [HDR_WORDS*DATA_W-1:0] r_hdr;
    logic [AGC_W-1:0]            r_agc;
    logic [SHIFT_W-1:0]          r_shift;
    logic [BW-1:0]               r_wr_ptr;
    logic [BW-1:0]               r_rd_ptr;
    logic [CW-1:0]               r_count;
    logic                        r_in_chip;
    logic                        r_accept;
    logic                        r_ovf;

    logic w_room;
    logic w_start;
    logic w_active;
    logic w_acc;
    logic w_wr;
    logic w_end;
    logic w_commit;

    assign w_room   = r_count < CW'(NUM_BUF);
    assign w_start  = i_wen & ~r_in_chip & (i_waddr == '0);
    assign w_active = i_wen & (r_in_chip | w_start);
    // Acceptance is decided once at the chip's first word
    assign w_acc    = r_in_chip ? r_accept : w_room;
    assign w_wr     = w_active & w_acc;
    assign w_end    = w_active & i_wlast;
    assign w_commit = w_end & w_acc;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[{r_wr_ptr, i_waddr}] <= i_wdata;
        end
        r_rd_data <= r_mem[{r_rd_ptr, i_rd_addr}];
        if (w_commit) begin
            r_info[r_wr_ptr] <= '{agc: r_agc, shift: r_shift, hdr: r_hdr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr     <= '0;
            r_agc     <= '0;
            r_shift   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_in_chip <= 1'b0;
            r_accept  <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_start) begin
                r_accept <= w_room;
                if (!w_room) begin
                    r_ovf <= 1'b1;
                end
            end
            if (w_end) begin
                r_in_chip <= 1'b0;
            end else if (w_start) begin
                r_in_chip <= 1'b1;
            end
            for (int h = 0; h < HDR_WORDS; h++) begin
                if (w_wr && i_waddr == ADDR_WIDTH'(HDR_START + h)) begin
                    r_hdr[h*DATA_W +: DATA_W] <= i_wdata;
                end
            end
            if (w_wr && i_waddr == ADDR_WIDTH'(PLD_START)) begin
                r_agc   <= i_agc;
                r_shift <= i_shift;
            end
            if (w_commit) begin
                r_wr_ptr <= r_wr_ptr + BW'(1);
            end
            if (i_release) begin
                r_rd_ptr <= r_rd_ptr + BW'(1);
            end
            unique case ({w_commit, i_release})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_info    = r_info[r_rd_ptr];
    assign o_pending = r_count != '0;
    assign o_tready  = w_room;
    assign o_ovf     = r_ovf;

endmodule

// File: rtl/cpri_rx_gen_mc.sv
// Multi-channel CPRI chip receiver: per-channel buffers, round-robin
// chip reader and two-stage payload output pipeline.
module cpri_rx_gen_mc
    import cpri_rx_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = DATA_W,
    parameter int ADDR_WIDTH  = 7,
    parameter int NUM_BUF     = 2,
    parameter int AGC_WIDTH   = AGC_W,
    parameter int SHIFT_WIDTH = SHIFT_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CH-1:0]               i_cpri_wen,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]    i_cpri_waddr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]    i_cpri_wdata,
    input  logic [NUM_CH-1:0]               i_cpri_wlast,
    input  logic [NUM_CH*AGC_WIDTH-1:0]     i_fft_agc,
    input  logic [NUM_CH*SHIFT_WIDTH-1:0]   i_fft_shift,
    input  logic                            i_rx_enable,
    input  logic                            i_rready,
    output logic                            o_tvalid,
    output logic                            o_sop,
    output logic                            o_tlast,
    output logic [$clog2(NUM_CH)-1:0]       o_ch_id,
    output logic [ADDR_WIDTH-1:0]           o_iq_raddr,
    output logic [DATA_WIDTH-1:0]           o_iq_rx_data,
    output logic [HDR_WORDS*DATA_WIDTH-1:0] o_rx_info,
    output logic [AGC_WIDTH-1:0]            o_fft_agc,
    output logic [SHIFT_WIDTH-1:0]          o_fft_shift,
    output logic [NUM_CH-1:0]               o_tready,
    output logic [NUM_CH-1:0]               o_ovf
);

    localparam int CH_W = $clog2(NUM_CH);

    logic [DATA_W-1:0] w_rd_data [NUM_CH];
    chip_info_t        w_info [NUM_CH];
    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_rel_vec;

    rd_state_t             r_state;
    logic [CH_W-1:0]       r_ch;
    logic [CH_W-1:0]       r_last;
    logic [ADDR_WIDTH-1:0] r_raddr;
    chip_info_t            r_cur;
    logic                  r_s1_vld;
    logic                  r_s1_sop;
    logic                  r_s1_last;
    logic [CH_W-1:0]       r_s1_ch;
    logic [ADDR_WIDTH-1:0] r_s1_addr;

    logic            w_issue;
    logic            w_rel;
    logic            w_sel_vld;
    logic [CH_W-1:0] w_sel_ch;
    logic [CH_W-1:0] w_idx;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        cpri_rx_ch_buf #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .NUM_BUF    (NUM_BUF)
        ) u_buf (
            .clk       (clk),
            .rst       (rst),
            .i_wen     (i_cpri_wen[c]),
            .i_waddr   (i_cpri_waddr[c*ADDR_WIDTH +: ADDR_WIDTH]),
            .i_wdata   (i_cpri_wdata[c*DATA_WIDTH +: DATA_WIDTH]),
            .i_wlast   (i_cpri_wlast[c]),
            .i_agc     (i_fft_agc[c*AGC_WIDTH +: AGC_WIDTH]),
            .i_shift   (i_fft_shift[c*SHIFT_WIDTH +: SHIFT_WIDTH]),
            .i_rd_addr (r_raddr),
            .i_release (w_rel_vec[c]),
            .o_rd_data (w_rd_data[c]),
            .o_info    (w_info[c]),
            .o_pending (w_pend[c]),
            .o_tready  (o_tready[c]),
            .o_ovf     (o_ovf[c])
        );
    end

    assign w_issue   = (r_state == READ) & i_rready;
    assign w_rel     = w_issue & (r_raddr == ADDR_WIDTH'(PLD_END));
    assign w_rel_vec = w_rel ? (NUM_CH'(1) << r_ch) : '0;

    // Walk backwards so the nearest pending channel after r_last wins
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_ch  = '0;
        w_idx     = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_idx = CH_W'((int'(r_last) + k) % NUM_CH);
            if (w_pend[w_idx]) begin
                w_sel_vld = 1'b1;
                w_sel_ch  = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ch         <= '0;
            r_last       <= '0;
            r_raddr      <= '0;
            r_cur        <= '0;
            r_s1_vld     <= 1'b0;
            r_s1_sop     <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_ch      <= '0;
            r_s1_addr    <= '0;
            o_tvalid     <= 1'b0;
            o_sop        <= 1'b0;
            o_tlast      <= 1'b0;
            o_ch_id      <= '0;
            o_iq_raddr   <= '0;
            o_iq_rx_data <= '0;
            o_rx_info    <= '0;
            o_fft_agc    <= '0;
            o_fft_shift  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_rx_enable && w_sel_vld) begin
                        r_ch    <= w_sel_ch;
                        r_raddr <= ADDR_WIDTH'(PLD_START);
                        r_cur   <= w_info[w_sel_ch];
                        r_state <= READ;
                    end
                end
                READ: begin
                    if (i_rready) begin
                        r_raddr <= r_raddr + ADDR_WIDTH'(1);
                        if (w_rel) begin
                            r_last  <= r_ch;
                            r_state <= IDLE;
                        end
                    end
                end
            endcase

            r_s1_vld  <= w_issue;
            r_s1_sop  <= w_issue & (r_raddr == ADDR_WIDTH'(PLD_START));
            r_s1_last <= w_rel;
            r_s1_ch   <= r_ch;
            r_s1_addr <= r_raddr;

            o_tvalid <= r_s1_vld;
            o_sop    <= r_s1_sop;
            o_tlast  <= r_s1_last;
            // Info follows the beats so it cannot change before tlast drains
            if (r_s1_vld) begin
                o_ch_id      <= r_s1_ch;
                o_iq_raddr   <= r_s1_addr;
                o_iq_rx_data <= w_rd_data[r_s1_ch];
                o_rx_info    <= r_cur.hdr;
                o_fft_agc    <= r_cur.agc;
                o_fft_shift  <= r_cur.shift;
            end
        end
    end

endmodule

// File: tb/tb_cpri_rx_gen_mc.sv
// Directed bench for cpri_rx_gen_mc: single chip, round robin,
// overflow, backpressure, reset mid-read and same-cycle commit/release.
module tb_cpri_rx_gen_mc;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   i_cpri_wen;
    logic [27:0]  i_cpri_waddr;
    logic [255:0] i_cpri_wdata;
    logic [3:0]   i_cpri_wlast;
    logic [63:0]  i_fft_agc;
    logic [255:0] i_fft_shift;
    logic         i_rx_enable;
    logic         i_rready;
    logic         o_tvalid;
    logic         o_sop;
    logic         o_tlast;
    logic [1:0]   o_ch_id;
    logic [6:0]   o_iq_raddr;
    logic [63:0]  o_iq_rx_data;
    logic [255:0] o_rx_info;
    logic [15:0]  o_fft_agc;
    logic [63:0]  o_fft_shift;
    logic [3:0]   o_tready;
    logic [3:0]   o_ovf;

    typedef struct {
        logic [6:0]   addr;
        logic [63:0]  data;
        logic [1:0]   ch;
        logic         sop;
        logic         last;
        logic [255:0] info;
        logic [15:0]  agc;
        logic [63:0]  shift;
        int           cyc;
    } beat_t;

    beat_t q[$];
    beat_t mon_b;
    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    int    en_cyc;

    cpri_rx_gen_mc dut (
        .clk          (clk),
        .rst          (rst),
        .i_cpri_wen   (i_cpri_wen),
        .i_cpri_waddr (i_cpri_waddr),
        .i_cpri_wdata (i_cpri_wdata),
        .i_cpri_wlast (i_cpri_wlast),
        .i_fft_agc    (i_fft_agc),
        .i_fft_shift  (i_fft_shift),
        .i_rx_enable  (i_rx_enable),
        .i_rready     (i_rready),
        .o_tvalid     (o_tvalid),
        .o_sop        (o_sop),
        .o_tlast      (o_tlast),
        .o_ch_id      (o_ch_id),
        .o_iq_raddr   (o_iq_raddr),
        .o_iq_rx_data (o_iq_rx_data),
        .o_rx_info    (o_rx_info),
        .o_fft_agc    (o_fft_agc),
        .o_fft_shift  (o_fft_shift),
        .o_tready     (o_tready),
        .o_ovf        (o_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_tvalid) begin
            mon_b.addr  = o_iq_raddr;
            mon_b.data  = o_iq_rx_data;
            mon_b.ch    = o_ch_id;
            mon_b.sop   = o_sop;
            mon_b.last  = o_tlast;
            mon_b.info  = o_rx_info;
            mon_b.agc   = o_fft_agc;
            mon_b.shift = o_fft_shift;
            mon_b.cyc   = cyc;
            q.push_back(mon_b);
        end
    end

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_chip(input int ch, input logic [31:0] tag,
                              input logic [63:0] hb,
                              input logic [15:0] agc, input int n);
        logic [63:0] d;
        i_fft_agc[ch*16 +: 16]   = agc;
        i_fft_shift[ch*64 +: 64] = {tag, 32'hC0FFEE00};
        for (int a = 0; a < n; a++) begin
            @(negedge clk);
            if (a >= 3 && a <= 6) d = hb + 64'(a);
            else d = {tag, 32'(a)};
            i_cpri_wen[ch]           = 1'b1;
            i_cpri_waddr[ch*7 +: 7]  = 7'(a);
            i_cpri_wdata[ch*64 +: 64] = d;
            i_cpri_wlast[ch]         = (a == 90);
        end
        @(negedge clk);
        i_cpri_wen[ch]   = 1'b0;
        i_cpri_wlast[ch] = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n,
                              input int budget, input bit tog);
        int c = 0;
        while (q.size() < n && c < budget) begin
            @(negedge clk);
            #1;
            if (tog) i_rready = ~i_rready;
            c++;
        end
        check({tag, "_wait"}, q.size() >= n, 1'b1);
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_chip(input string nm, input int s, input int ch,
                              input logic [31:0] tag,
                              input logic [63:0] hb,
                              input logic [15:0] agc);
        int bad_a = 0;
        int bad_d = 0;
        int bad_f = 0;
        int bad_m = 0;
        logic [255:0] info;
        beat_t b;
        info = {hb + 64'd6, hb + 64'd5, hb + 64'd4, hb + 64'd3};
        if (q.size() < s + 84) begin
            check({nm, "_beats"}, q.size(), s + 84);
            return;
        end
        for (int k = 0; k < 84; k++) begin
            b = q[s+k];
            if (b.addr != 7'(7 + k)) bad_a++;
            if (b.data != {tag, 32'(7 + k)}) bad_d++;
            if (b.sop != (k == 0) || b.last != (k == 83)) bad_f++;
            if (b.ch != 2'(ch) || b.info != info || b.agc != agc ||
                b.shift != {tag, 32'hC0FFEE00}) bad_m++;
        end
        check({nm, "_addr_seq"}, bad_a, 0);
        check({nm, "_data"}, bad_d, 0);
        check({nm, "_sop_last"}, bad_f, 0);
        check({nm, "_meta_held"}, bad_m, 0);
        check({nm, "_info"}, q[s].info, info);
        check({nm, "_ch"}, q[s].ch, ch);
    endtask

    initial begin
        #300us;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        i_cpri_wen   = '0;
        i_cpri_waddr = '0;
        i_cpri_wdata = '0;
        i_cpri_wlast = '0;
        i_fft_agc    = '0;
        i_fft_shift  = '0;
        i_rx_enable  = 1'b0;
        i_rready     = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tvalid", o_tvalid, 1'b0);
        check("rst_tready", o_tready, 4'hF);
        check("rst_ovf", o_ovf, 4'h0);
        check("rst_info", o_rx_info, 256'd0);
        check("rst_data", o_iq_rx_data, 64'd0);
        rst = 1'b0;

        // single chip on ch0
        write_chip(0, 32'h0, 64'hA0, 16'h55, 91);
        check("t1_tready", o_tready, 4'hF);
        @(negedge clk);
        q.delete();
        i_rx_enable = 1'b1;
        en_cyc = cyc;
        wait_beats("t1", 84, 300, 1'b0);
        drain(10);
        check("t1_count", q.size(), 84);
        if (q.size() > 0) check("t1_latency", q[0].cyc - en_cyc, 3);
        check_chip("t1", 0, 0, 32'h0, 64'hA0, 16'h55);

        // round robin: serve ch1, then ch0+ch2 pending
        q.delete();
        write_chip(1, 32'h11, 64'h1100, 16'h11, 91);
        wait_beats("t2a", 84, 300, 1'b0);
        drain(10);
        check_chip("t2a", 0, 1, 32'h11, 64'h1100, 16'h11);
        i_rx_enable = 1'b0;
        q.delete();
        write_chip(0, 32'h20, 64'h2000, 16'h20, 91);
        write_chip(2, 32'h22, 64'h2200, 16'h22, 91);
        i_rx_enable = 1'b1;
        wait_beats("t2", 168, 600, 1'b0);
        drain(10);
        check("t2_count", q.size(), 168);
        check_chip("t2_ch2", 0, 2, 32'h22, 64'h2200, 16'h22);
        check_chip("t2_ch0", 84, 0, 32'h20, 64'h2000, 16'h20);
        if (q.size() >= 168) check("t2_bubble", q[84].cyc - q[83].cyc, 2);

        // overflow on ch1
        i_rx_enable = 1'b0;
        q.delete();
        write_chip(1, 32'h31, 64'h3100, 16'h31, 91);
        write_chip(1, 32'h32, 64'h3200, 16'h32, 91);
        check("t3_tready_full", o_tready[1], 1'b0);
        check("t3_ovf_pre", o_ovf, 4'h0);
        write_chip(1, 32'h33, 64'h3300, 16'h33, 91);
        check("t3_ovf", o_ovf, 4'b0010);
        i_rx_enable = 1'b1;
        wait_beats("t3", 168, 600, 1'b0);
        drain(20);
        check("t3_count", q.size(), 168);
        check_chip("t3a", 0, 1, 32'h31, 64'h3100, 16'h31);
        check_chip("t3b", 84, 1, 32'h32, 64'h3200, 16'h32);
        check("t3_tready_free", o_tready, 4'hF);

        // backpressure
        i_rx_enable = 1'b0;
        q.delete();
        write_chip(2, 32'h44, 64'h4400, 16'h44, 91);
        i_rx_enable = 1'b1;
        wait_beats("t4", 84, 600, 1'b1);
        i_rready = 1'b1;
        drain(10);
        check("t4_count", q.size(), 84);
        check_chip("t4", 0, 2, 32'h44, 64'h4400, 16'h44);

        // reset mid-read with a partial chip on ch3
        i_rx_enable = 1'b0;
        q.delete();
        write_chip(3, 32'h50, 64'h5000, 16'h50, 46);
        write_chip(0, 32'h51, 64'h5100, 16'h51, 91);
        i_rx_enable = 1'b1;
        wait_beats("t5pre", 40, 300, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("t5_tvalid", o_tvalid, 1'b0);
        check("t5_data", o_iq_rx_data, 64'd0);
        check("t5_raddr", o_iq_raddr, 7'd0);
        check("t5_info", o_rx_info, 256'd0);
        check("t5_tready", o_tready, 4'hF);
        check("t5_ovf", o_ovf, 4'h0);
        rst = 1'b0;
        q.delete();
        write_chip(3, 32'h53, 64'h5300, 16'h53, 91);
        wait_beats("t5", 84, 300, 1'b0);
        drain(20);
        check("t5_count", q.size(), 84);
        check_chip("t5", 0, 3, 32'h53, 64'h5300, 16'h53);

        // commit on ch0 in the cycle ch0 releases at PLD_END
        i_rx_enable = 1'b0;
        q.delete();
        write_chip(0, 32'h61, 64'h6100, 16'h61, 91);
        fork
            write_chip(0, 32'h62, 64'h6200, 16'h62, 91);
            begin
                repeat (7) @(negedge clk);
                i_rx_enable = 1'b1;
            end
        join
        #1;
        check("t6_tready", o_tready[0], 1'b1);
        wait_beats("t6", 168, 400, 1'b0);
        drain(20);
        check("t6_count", q.size(), 168);
        check_chip("t6a", 0, 0, 32'h61, 64'h6100, 16'h61);
        check_chip("t6b", 84, 0, 32'h62, 64'h6200, 16'h62);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
